// File: rtl/microsequencer.sv
// Next-address generator for the microprogrammed control unit.
// It holds the 7-bit microstore index and picks the next one each cycle.
// Candidates are the sequencing fields, the decoder entry address, one
// qualified status condition and a small return-address stack.
//
// ns_sel | meaning
// 000    | DECODE  : dec_addr
// 001    | FETCH   : FETCH_ADDR
// 010    | JUMP    : cr_addr
// 011    | INC     : index + 1
// 100    | CJUMP   : c ? cr_addr : index + 1
// 101    | CDECODE : c ? dec_addr : index + 1
// 110    | CALL    : push index + 1, go to cr_addr
// 111    | RET     : pop top of stack (FETCH_ADDR when empty)
module microsequencer #(
  parameter logic [6:0] RESET_ADDR  = 7'd0,
  parameter logic [6:0] FETCH_ADDR  = 7'd1,
  parameter int         STACK_DEPTH = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       stall,
  input  logic [2:0] ns_sel,
  input  logic [1:0] cond_sel,
  input  logic       inv,
  input  logic [6:0] cr_addr,
  input  logic [6:0] dec_addr,
  input  logic       moc,
  input  logic       cond_pass,
  input  logic       irq,
  output logic [6:0] index,
  output logic [2:0] sp,
  output logic       ovf,
  output logic       unf
);

  localparam logic [2:0] SP_FULL = 3'(STACK_DEPTH);

  // stk[0] is the oldest entry; stk[sp-1] is the top.
  logic [6:0] stk [STACK_DEPTH];
  logic       cond_raw;
  logic       c;
  logic [6:0] inc;
  logic [6:0] top;
  logic [6:0] nxt;
  logic       do_call;
  logic       do_ret;

  assign c       = cond_raw ^ inv;
  assign inc     = index + 7'd1;
  assign do_call = (ns_sel == 3'b110);
  assign do_ret  = (ns_sel == 3'b111);

  // Pick the status condition named by cond_sel.
  always_comb begin
    case (cond_sel)
      2'b00:   cond_raw = moc;
      2'b01:   cond_raw = cond_pass;
      2'b10:   cond_raw = irq;
      default: cond_raw = 1'b1;
    endcase
  end

  // Top of stack; an empty stack returns to the fetch routine.
  always_comb begin
    top = FETCH_ADDR;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == 3'(i + 1)) top = stk[i];
    end
  end

  // Next-index select from the current microinstruction fields.
  always_comb begin
    case (ns_sel)
      3'b000:  nxt = dec_addr;
      3'b001:  nxt = FETCH_ADDR;
      3'b010:  nxt = cr_addr;
      3'b011:  nxt = inc;
      3'b100:  nxt = c ? cr_addr : inc;
      3'b101:  nxt = c ? dec_addr : inc;
      3'b110:  nxt = cr_addr;
      default: nxt = top;
    endcase
  end

  // Index register, return stack and sticky error flags.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      index <= RESET_ADDR;
      sp    <= 3'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= 7'd0;
    end else if (!stall) begin
      index <= nxt;
      if (do_call) begin
        if (sp == SP_FULL) begin
          // Full: drop the oldest return address to make room.
          for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i + 1];
          stk[STACK_DEPTH - 1] <= inc;
          ovf <= 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp == 3'(i)) stk[i] <= inc;
          end
          sp <= sp + 3'd1;
        end
      end else if (do_ret) begin
        if (sp == 3'd0) unf <= 1'b1;
        else            sp  <= sp - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus random
// stimulus, all checked against a queue-based behavioural model.
module tb_microsequencer;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       stall = 1'b0;
  logic [2:0] ns_sel = 3'b011;
  logic [1:0] cond_sel = 2'b00;
  logic       inv = 1'b0;
  logic [6:0] cr_addr = 7'd0;
  logic [6:0] dec_addr = 7'd0;
  logic       moc = 1'b0;
  logic       cond_pass = 1'b0;
  logic       irq = 1'b0;
  logic [6:0] index;
  logic [2:0] sp;
  logic       ovf;
  logic       unf;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_index = 0;
  int m_ovf   = 0;
  int m_unf   = 0;
  int m_stk[$];

  microsequencer #(.RESET_ADDR(7'd0), .FETCH_ADDR(7'd1), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .stall(stall), .ns_sel(ns_sel), .cond_sel(cond_sel),
    .inv(inv), .cr_addr(cr_addr), .dec_addr(dec_addr), .moc(moc),
    .cond_pass(cond_pass), .irq(irq), .index(index), .sp(sp), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_index = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stk.delete();
  endtask

  // Apply the sequencing rules once, using the inputs currently driven.
  task automatic model_step();
    int cnd;
    int nx_inc;
    if (!clr) begin
      model_reset();
      return;
    end
    if (stall) return;
    case (cond_sel)
      2'd0:    cnd = int'(moc);
      2'd1:    cnd = int'(cond_pass);
      2'd2:    cnd = int'(irq);
      default: cnd = 1;
    endcase
    if (inv) cnd = 1 - cnd;
    nx_inc = (m_index + 1) % 128;
    case (ns_sel)
      3'd0: m_index = int'(dec_addr);
      3'd1: m_index = 1;
      3'd2: m_index = int'(cr_addr);
      3'd3: m_index = nx_inc;
      3'd4: m_index = (cnd != 0) ? int'(cr_addr) : nx_inc;
      3'd5: m_index = (cnd != 0) ? int'(dec_addr) : nx_inc;
      3'd6: begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_stk.push_back(nx_inc);
        m_index = int'(cr_addr);
      end
      default: begin
        if (m_stk.size() == 0) begin
          m_index = 1;
          m_unf   = 1;
        end else begin
          m_index = m_stk.pop_back();
        end
      end
    endcase
  endtask

  task automatic check_state();
    check_val("index", 32'(index), m_index);
    check_val("sp",    32'(sp),    m_stk.size());
    check_val("ovf",   32'(ovf),   m_ovf);
    check_val("unf",   32'(unf),   m_unf);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic drive(input logic [2:0] ns, input logic [6:0] cr, input logic [6:0] dec);
    ns_sel   = ns;
    cr_addr  = cr;
    dec_addr = dec;
    step();
  endtask

  initial begin
    // reset asserted away from any clock edge
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_state();
    step();                       // clock edge with clr held low
    check_val("rst_hold_index", 32'(index), 0);
    #2 clr = 1'b1;

    // increment from reset
    for (int i = 1; i <= 3; i++) begin
      drive(3'b011, 7'd0, 7'd0);
      check_val("inc_index", 32'(index), i);
    end

    // decode, jump, wrap
    drive(3'b010, 7'h05, 7'h00);
    drive(3'b000, 7'h00, 7'h2A);
    check_val("decode", 32'(index), 'h2A);
    drive(3'b010, 7'h7F, 7'h00);
    drive(3'b011, 7'h00, 7'h00);
    check_val("wrap", 32'(index), 0);

    // memory wait loop on moc
    drive(3'b010, 7'h10, 7'h00);
    cond_sel = 2'b00; inv = 1'b1; moc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b100, 7'h10, 7'h00);
      check_val("moc_wait", 32'(index), 'h10);
    end
    moc = 1'b1;
    drive(3'b100, 7'h10, 7'h00);
    check_val("moc_done", 32'(index), 'h11);
    cond_sel = 2'b11; inv = 1'b0; moc = 1'b0;
    drive(3'b100, 7'h33, 7'h00);
    check_val("cjump_const", 32'(index), 'h33);
    cond_sel = 2'b11; inv = 1'b1;
    drive(3'b101, 7'h00, 7'h44);
    check_val("cdecode_not", 32'(index), 'h34);
    inv = 1'b0;

    // call / return
    drive(3'b010, 7'h20, 7'h00);
    drive(3'b110, 7'h40, 7'h00);
    drive(3'b110, 7'h50, 7'h00);
    check_val("call_sp", 32'(sp), 2);
    drive(3'b111, 7'h00, 7'h00);
    check_val("ret1", 32'(index), 'h41);
    drive(3'b111, 7'h00, 7'h00);
    check_val("ret2", 32'(index), 'h21);
    drive(3'b111, 7'h00, 7'h00);
    check_val("ret_empty", 32'(index), 'h01);
    check_val("unf_set", 32'(unf), 1);

    // overflow
    drive(3'b010, 7'h03, 7'h00);
    drive(3'b110, 7'h08, 7'h00);
    drive(3'b110, 7'h0C, 7'h00);
    drive(3'b110, 7'h30, 7'h00);
    check_val("ovf_set", 32'(ovf), 1);
    check_val("ovf_sp", 32'(sp), 2);
    drive(3'b111, 7'h00, 7'h00);
    check_val("ovf_ret1", 32'(index), 'h0D);
    drive(3'b111, 7'h00, 7'h00);
    check_val("ovf_ret2", 32'(index), 'h09);

    // stall during a call
    drive(3'b110, 7'h60, 7'h00);
    stall = 1'b1;
    drive(3'b110, 7'h70, 7'h00);
    check_val("stall_index", 32'(index), 'h60);
    check_val("stall_sp", 32'(sp), 1);
    stall = 1'b0;
    drive(3'b111, 7'h00, 7'h00);
    check_val("stall_ret", 32'(index), 'h0A);

    // asynchronous reset pulse between edges
    drive(3'b110, 7'h15, 7'h00);
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_val("async_index", 32'(index), 0);
    check_val("async_sp", 32'(sp), 0);
    check_val("async_ovf", 32'(ovf), 0);
    check_val("async_unf", 32'(unf), 0);
    #1 clr = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(7) == 0);
      cond_sel  = 2'($urandom_range(3));
      inv       = 1'($urandom_range(1));
      moc       = 1'($urandom_range(1));
      cond_pass = 1'($urandom_range(1));
      irq       = 1'($urandom_range(1));
      clr       = ($urandom_range(63) != 0);
      drive(3'($urandom_range(7)), 7'($urandom_range(127)), 7'($urandom_range(127)));
      clr = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-address generator for the microprogrammed control unit. It holds the 7-bit microstore index register that addresses the control ROM, which returns a 45-bit microinstruction. Each cycle it selects the next index from the current microinstruction's sequencing fields, the instruction-decoder entry address, one qualified status condition, and a small return-address stack.

## Interface
- RESET_ADDR, 7'd0: index loaded on reset.
- FETCH_ADDR, 7'd1: fetch-routine entry; target of ns_sel=001 and of a return on an empty stack.
- STACK_DEPTH, 2: return-address stack entries, 1..4.

- clk, in, 1: single clock; all state updates on the rising edge.
- clr, in, 1: reset, asynchronous, active-low.
- stall, in, 1: hold the whole state when high.
- ns_sel, in, 3: next-state select field of the current microinstruction.
- cond_sel, in, 2: condition select. 00 moc, 01 cond_pass, 10 irq, 11 constant 1.
- inv, in, 1: invert the selected condition.
- cr_addr, in, 7: control-register target address field.
- dec_addr, in, 7: entry address from the instruction decoder.
- moc, in, 1: memory operation complete.
- cond_pass, in, 1: ARM condition-code test passed.
- irq, in, 1: interrupt pending, already level-qualified.
- index, out, 7: registered microstore address, driven straight from the state register.
- sp, out, 3: stack occupancy, 0..STACK_DEPTH.
- ovf, out, 1: sticky, set by a call while the stack is full.
- unf, out, 1: sticky, set by a return while the stack is empty.

## Operation
- c = selected condition XOR inv. inc = index + 1, 7-bit, wraps 127→0.
- ns_sel decode gives next index:
  - 000 DECODE: dec_addr.
  - 001 FETCH: FETCH_ADDR.
  - 010 JUMP: cr_addr.
  - 011 INC: inc.
  - 100 CJUMP: c ? cr_addr : inc.
  - 101 CDECODE: c ? dec_addr : inc.
  - 110 CALL: push inc, then cr_addr.
  - 111 RET: pop top of stack. If the stack is empty, go to FETCH_ADDR.
- Memory wait: CJUMP with cond_sel=00, inv=1 and cr_addr equal to the current index spins until moc=1. No dedicated wait state exists.
- Stack is LIFO. Push increments sp; pop decrements sp.
- CALL when sp=STACK_DEPTH:
  - the oldest entry is discarded and the others shift down;
  - inc becomes the new top;
  - sp stays at STACK_DEPTH;
  - ovf is set.
- RET when sp=0: next index is FETCH_ADDR, sp stays 0, unf is set.
- stall=1 freezes index, the stack, sp and the flags, whatever ns_sel holds. Inputs are ignored that cycle.
- Only clr clears ovf and unf.

## Timing
- Reset (clr=0, asynchronous): index=RESET_ADDR, sp=0, ovf=0, unf=0, stack entries=0. These values hold while clr is low.
- Reset mid-operation discards any in-flight call or return.
- The first update occurs on the first rising clk after clr deasserts.
- The ROM is combinational, so the microinstruction for index is valid in the same cycle.
- The next index registers on the next edge. Throughput is one microinstruction per cycle.
- The next-index logic is purely combinational from the current fields and status inputs. No extra pipeline stage exists.
- Status inputs (moc, cond_pass, irq) are sampled only at the rising edge.
- On CALL, the pushed value is the index+1 from that same cycle.

## Test plan
- Reset and increment: clr low, then ns_sel=011 for 3 cycles → index reads 0 during reset, then 1, 2, 3. sp=0, ovf=0, unf=0.
- Decode, jump and wrap:
  - with index=5, dec_addr=0x2A and ns_sel=000 → index=0x2A;
  - then ns_sel=010 with cr_addr=0x7F → 0x7F;
  - then ns_sel=011 → 0x00.
- MOC wait at index=0x10 (ns_sel=100, cond_sel=00, inv=1, cr_addr=0x10):
  - with moc=0 for 4 cycles, index stays at 0x10;
  - moc=1 → index=0x11 on the next edge;
  - repeat with inv=0 and cond_sel=11 → jumps immediately.
- Call/return, STACK_DEPTH=2:
  - CALL at index 0x20 (cr_addr=0x40), then CALL at 0x40 (cr_addr=0x50) → sp=2.
  - RET, RET → index 0x41, then 0x21, and sp=0.
  - Third RET → index=0x01, unf=1.
- Overflow: three CALLs from indexes 0x03, 0x08 and 0x0C → ovf=1, sp=2. Two RETs return 0x0D, then 0x09.
- Stall and async reset:
  - stall=1 during a CALL → index, sp and stack are unchanged.
  - Pulse clr low mid-cycle → index=0 immediately, sp=0, and flags clear without waiting for a clock edge.
